// File: rtl/l2_req_out_queue.sv
// Outbound request queue between the L2 core and the NoC: a DEPTH-entry FIFO
// whose head entry is presented straight from storage, with registered status flags.
module l2_req_out_queue #(
    parameter int DEPTH  = 4,
    parameter int COH_W  = 2,
    parameter int ADDR_W = 28,
    parameter int LINE_W = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [COH_W-1:0]         in_coh_msg,
    input  logic                     in_hprot,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic [LINE_W-1:0]        in_line,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [COH_W-1:0]         out_coh_msg,
    output logic                     out_hprot,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [LINE_W-1:0]        out_line,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = COH_W + 1 + ADDR_W + LINE_W;

    localparam logic [0:0]       ST_EMPTY    = 1'b0;
    localparam logic [0:0]       ST_NONEMPTY = 1'b1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE     = PTR_W'(1);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [0:0]         state_q, state_d;
    logic               full_q, full_d;
    logic               push_s, pop_s;
    logic [ENTRY_W-1:0] head_s;

    assign in_ready  = ~full_q;
    assign out_valid = (state_q == ST_NONEMPTY);
    assign empty     = (state_q == ST_EMPTY);
    assign full      = full_q;
    assign count     = count_q;

    assign push_s = in_valid & in_ready;
    assign pop_s  = out_valid & out_ready;

    // Head entry comes from storage only, so nothing on in_* reaches out_* in the same cycle.
    assign head_s = mem_q[rd_ptr_q];
    assign {out_coh_msg, out_hprot, out_addr, out_line} = head_s;

    // Next-state for pointers, occupancy, FSM and full flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        state_d  = state_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_EMPTY: begin
                if (push_s) begin
                    state_d = ST_NONEMPTY;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_NONEMPTY: begin
                if (pop_s && !push_s && (count_q == CNT_ONE)) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_NONEMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        full_d = (count_d == CNT_FULL);
    end

    // Control state with asynchronous reset; all entries are discarded on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            state_q  <= ST_EMPTY;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            full_q   <= full_d;
        end
    end

    // Entry storage, written only on an accepted push; contents need no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {in_coh_msg, in_hprot, in_addr, in_line};
        end
    end

endmodule

// File: tb/tb_l2_req_out_queue.sv
// Scoreboard bench for l2_req_out_queue: a queue model predicts flags, occupancy
// and the head entry every cycle; accepted pushes enqueue, accepted pops dequeue.
module tb_l2_req_out_queue;

    localparam int DEPTH   = 4;
    localparam int COH_W   = 2;
    localparam int ADDR_W  = 28;
    localparam int LINE_W  = 128;
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = COH_W + 1 + ADDR_W + LINE_W;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [COH_W-1:0]    in_coh_msg;
    logic                in_hprot;
    logic [ADDR_W-1:0]   in_addr;
    logic [LINE_W-1:0]   in_line;
    logic                out_ready;
    logic                out_valid;
    logic [COH_W-1:0]    out_coh_msg;
    logic                out_hprot;
    logic [ADDR_W-1:0]   out_addr;
    logic [LINE_W-1:0]   out_line;
    logic [CNT_W-1:0]    count;
    logic                full;
    logic                empty;

    logic [ENTRY_W-1:0]  sb [$];
    int                  n_checks = 0;
    int                  n_fail   = 0;

    l2_req_out_queue #(.DEPTH(DEPTH), .COH_W(COH_W), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_coh_msg(in_coh_msg), .in_hprot(in_hprot), .in_addr(in_addr), .in_line(in_line),
        .out_ready(out_ready), .out_valid(out_valid),
        .out_coh_msg(out_coh_msg), .out_hprot(out_hprot), .out_addr(out_addr), .out_line(out_line),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ENTRY_W-1:0] make_entry(input logic [ADDR_W-1:0] addr);
        logic [COH_W-1:0]  c;
        logic              h;
        logic [LINE_W-1:0] l;
        c = COH_W'($urandom);
        h = 1'($urandom);
        l = {$urandom, $urandom, $urandom, $urandom};
        return {c, h, addr, l};
    endfunction

    task automatic drive(input logic v, input logic [ENTRY_W-1:0] e, input logic r);
        in_valid = v;
        {in_coh_msg, in_hprot, in_addr, in_line} = e;
        out_ready = r;
    endtask

    // Entered at a falling edge with inputs set; checks, updates the model, advances one cycle.
    task automatic tick(output logic pushed);
        int   sz;
        logic acc_push;
        logic acc_pop;
        #1;
        sz = sb.size();
        check_eq("in_ready",  256'(in_ready),  256'(sz < DEPTH));
        check_eq("out_valid", 256'(out_valid), 256'(sz != 0));
        check_eq("count",     256'(count),     256'(sz));
        check_eq("full",      256'(full),      256'(sz == DEPTH));
        check_eq("empty",     256'(empty),     256'(sz == 0));
        if (sz != 0)
            check_eq("head", 256'({out_coh_msg, out_hprot, out_addr, out_line}), 256'(sb[0]));
        acc_push = in_valid && (sz < DEPTH);
        acc_pop  = out_ready && (sz != 0);
        if (acc_pop)
            void'(sb.pop_front());
        if (acc_push)
            sb.push_back({in_coh_msg, in_hprot, in_addr, in_line});
        pushed = acc_push;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        logic p;
        drive(1'b0, '0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) break;
            tick(p);
        end
        check_eq("drain_done", 256'(sb.size()), 256'(0));
        tick(p);
    endtask

    // Hold one entry on the input until the model says it was accepted.
    task automatic push_hold(input logic [ENTRY_W-1:0] e, input logic r);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 40 && !p; i++) begin
            drive(1'b1, e, r);
            tick(p);
        end
        check_eq("push_accepted", 256'(p), 256'(1));
    endtask

    initial begin
        logic               p;
        logic [ENTRY_W-1:0] e;
        int                 idx;

        rst = 1'b0;
        drive(1'b0, '0, 1'b0);
        #12;
        check_eq("rst_out_valid", 256'(out_valid), 256'(0));
        check_eq("rst_count",     256'(count),     256'(0));
        check_eq("rst_in_ready",  256'(in_ready),  256'(1));
        check_eq("rst_empty",     256'(empty),     256'(1));
        check_eq("rst_full",      256'(full),      256'(0));
        @(negedge clk);
        rst = 1'b1;
        tick(p);

        // single pass, one-cycle latency
        e = {2'd1, 1'b1, 28'h000ABC, 128'hDEAD0000_11112222_33334444_0000BEEF};
        drive(1'b1, e, 1'b1);
        tick(p);
        drive(1'b0, '0, 1'b1);
        tick(p);
        tick(p);

        // fill: addr 1..4 accepted, 5 held until space opens
        for (int a = 1; a <= 4; a++) begin
            drive(1'b1, make_entry(ADDR_W'(a)), 1'b0);
            tick(p);
        end
        e = make_entry(ADDR_W'(5));
        drive(1'b1, e, 1'b0);
        tick(p);
        check_eq("fill_5_held", 256'(p), 256'(0));
        push_hold(e, 1'b1);
        drain();

        // full with simultaneous push and pop
        for (int a = 16; a < 20; a++) begin
            drive(1'b1, make_entry(ADDR_W'(a)), 1'b0);
            tick(p);
        end
        e = make_entry(ADDR_W'(20));
        drive(1'b1, e, 1'b1);
        tick(p);
        check_eq("full_pop_only", 256'(p), 256'(0));
        drive(1'b1, e, 1'b1);
        tick(p);
        check_eq("full_push_pop", 256'(p), 256'(1));
        drain();

        // wrap-around with random backpressure
        idx = 0;
        e = make_entry(ADDR_W'(32'h100));
        for (int c = 0; c < 400 && idx < 3 * DEPTH + 1; c++) begin
            drive(1'b1, e, 1'($urandom));
            tick(p);
            if (p) begin
                idx++;
                e = make_entry(ADDR_W'(32'h100 + idx));
            end
        end
        check_eq("wrap_all_pushed", 256'(idx), 256'(3 * DEPTH + 1));
        drain();

        // head stability while pushes continue and out_ready stays low
        drive(1'b1, make_entry(ADDR_W'(32'h200)), 1'b0);
        tick(p);
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, make_entry(ADDR_W'(32'h201 + c)), 1'b0);
            tick(p);
        end
        drain();

        // asynchronous reset with three entries queued
        for (int a = 0; a < 3; a++) begin
            drive(1'b1, make_entry(ADDR_W'(32'h300 + a)), 1'b0);
            tick(p);
        end
        drive(1'b0, '0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_out_valid", 256'(out_valid), 256'(0));
        check_eq("arst_count",     256'(count),     256'(0));
        check_eq("arst_in_ready",  256'(in_ready),  256'(1));
        check_eq("arst_empty",     256'(empty),     256'(1));
        sb.delete();
        #1;
        rst = 1'b1;
        @(negedge clk);
        tick(p);
        drive(1'b1, make_entry(ADDR_W'(7)), 1'b1);
        tick(p);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
